// File: rtl/imm_gen_pipe.sv
// Purpose : multi-lane RV32/RV64 immediate generator feeding rename through a 2-entry skid buffer.
// Latency : one cycle; a bundle accepted at cycle N is on imm_o at N+1 when the consumer is not stalling.
// Backpressure: ready_o is registered and drops only when both main and skid registers hold a bundle.
//
// Ports:
//   clk_i, rstn_i (sync, active-low), flush_i (kills every buffered bundle)
//   valid_i/ready_o, lane_valid_i, instr_i   : decode-side handshake, lane k at instr_i[32k+:32]
//   valid_o/ready_i, lane_valid_o, imm_o,
//   imm_fmt_o                                : rename-side handshake, lane k at imm_o[XLEN*k+:XLEN]
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int LANES = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [LANES-1:0]        lane_valid_i,
    input  logic [LANES*32-1:0]     instr_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [LANES-1:0]        lane_valid_o,
    output logic [LANES*XLEN-1:0]   imm_o,
    output logic [LANES*3-1:0]      imm_fmt_o
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Packed lane arrays flatten exactly into the lane-k-at-[W*k+:W] output layout.
    typedef struct packed {
        logic [LANES-1:0]           lane_vld;
        logic [LANES-1:0][XLEN-1:0] imm;
        logic [LANES-1:0][2:0]      fmt;
    } bundle_t;

    // Returns {fmt, imm} for one instruction.
    function automatic logic [XLEN+2:0] decode(input logic [31:0] ins);
        logic signed [11:0] s_i;
        logic signed [11:0] s_s;
        logic signed [12:0] s_b;
        logic signed [31:0] s_u;
        logic signed [20:0] s_j;
        logic signed [4:0]  s_v;
        logic [2:0]         f3;
        logic [XLEN-1:0]    imm;
        fmt_e               fmt;
        s_i = ins[31:20];
        s_s = {ins[31:25], ins[11:7]};
        s_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        s_u = {ins[31:12], 12'b0};
        s_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        s_v = ins[19:15];
        f3  = ins[14:12];
        imm = '0;
        fmt = FMT_NONE;
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin fmt = FMT_U; imm = XLEN'(s_u); end
            7'b1101111:             begin fmt = FMT_J; imm = XLEN'(s_j); end
            7'b1100111, 7'b0000011,
            7'b0000111:             begin fmt = FMT_I; imm = XLEN'(s_i); end
            7'b0100011, 7'b0100111: begin fmt = FMT_S; imm = XLEN'(s_s); end
            7'b1100011:             begin fmt = FMT_B; imm = XLEN'(s_b); end
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    fmt = FMT_SHAMT;
                    imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'(s_i);
                end
            end
            7'b0011011: begin
                // Word-sized OP-IMM exists only on RV64.
                if (XLEN == 64) begin
                    if (f3 == 3'b001 || f3 == 3'b101) begin
                        fmt = FMT_SHAMT;
                        imm = XLEN'(ins[24:20]);
                    end else begin
                        fmt = FMT_I;
                        imm = XLEN'(s_i);
                    end
                end
            end
            7'b1110011: begin
                if (f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111) begin
                    fmt = FMT_ZIMM;
                    imm = XLEN'(ins[19:15]);
                end else if (f3 != 3'b100) begin
                    fmt = FMT_I;
                    imm = XLEN'(s_i);
                end
            end
            7'b1010111: begin
                // OPIVI simm5 sign-extends from bit 19, not bit 31.
                if (f3 == 3'b011) begin
                    fmt = FMT_I;
                    imm = XLEN'(s_v);
                end
            end
            default: begin
                fmt = FMT_NONE;
                imm = '0;
            end
        endcase
        return {fmt, imm};
    endfunction

    bundle_t dec_b;
    bundle_t main_q;
    bundle_t skid_q;
    state_e  state_q;
    state_e  state_d;
    logic    ready_q;
    logic    acc;
    logic    drn;
    logic    ld_main_in;
    logic    ld_main_skid;
    logic    ld_skid;

    always_comb begin
        dec_b          = '0;
        dec_b.lane_vld = lane_valid_i;
        for (int k = 0; k < LANES; k++) begin
            if (lane_valid_i[k]) begin
                {dec_b.fmt[k], dec_b.imm[k]} = decode(instr_i[32*k +: 32]);
            end
        end
    end

    assign valid_o      = (state_q != ST_EMPTY);
    assign ready_o      = ready_q;
    assign acc          = valid_i & ready_q;
    assign drn          = valid_o & ready_i;
    assign lane_valid_o = main_q.lane_vld;
    assign imm_o        = main_q.imm;
    assign imm_fmt_o    = main_q.fmt;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d    = ST_ONE;
                    ld_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && drn) begin
                    ld_main_in = 1'b1;
                end else if (acc) begin
                    state_d = ST_TWO;
                    ld_skid = 1'b1;
                end else if (drn) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drn) begin
                    state_d      = ST_ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            // Registered ready: it tracks the next state, so it is never a comb path from ready_i.
            ready_q <= (state_d != ST_TWO);
            if (ld_main_in) begin
                main_q <= dec_b;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= dec_b;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [1:0]   lane_valid_i;
    logic [63:0]  instr_i;
    logic         valid_o;
    logic         ready_i;
    logic [1:0]   lane_valid_o;
    logic [127:0] imm_o;
    logic [5:0]   imm_fmt_o;

    logic         flush32;
    logic         valid32;
    logic         ready_o32;
    logic [0:0]   lane_valid32;
    logic [31:0]  instr32;
    logic         valid_o32;
    logic         ready32;
    logic [0:0]   lane_valid_o32;
    logic [31:0]  imm32;
    logic [2:0]   fmt32;

    always #5 clk_i = ~clk_i;

    imm_gen_pipe #(.XLEN(64), .LANES(2)) u_dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .lane_valid_i (lane_valid_i),
        .instr_i      (instr_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .lane_valid_o (lane_valid_o),
        .imm_o        (imm_o),
        .imm_fmt_o    (imm_fmt_o)
    );

    imm_gen_pipe #(.XLEN(32), .LANES(1)) u_dut32 (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_i      (flush32),
        .valid_i      (valid32),
        .ready_o      (ready_o32),
        .lane_valid_i (lane_valid32),
        .instr_i      (instr32),
        .valid_o      (valid_o32),
        .ready_i      (ready32),
        .lane_valid_o (lane_valid_o32),
        .imm_o        (imm32),
        .imm_fmt_o    (fmt32)
    );

    typedef struct packed {
        logic [1:0]        lv;
        logic [1:0][63:0]  imm;
        logic [1:0][2:0]   fmt;
    } exp_t;

    localparam logic [31:0] ADDI   = 32'hFFF00093;
    localparam logic [31:0] SW     = 32'hFE20AE23;
    localparam logic [31:0] JAL    = 32'hFF9FF06F;
    localparam logic [31:0] SRAI   = 32'h43F0D093;
    localparam logic [31:0] CSRRWI = 32'h3002D073;
    localparam logic [31:0] LUI    = 32'h800000B7;
    localparam logic [31:0] SLLIW  = 32'h01F0909B;
    localparam logic [31:0] BEQ    = 32'hFE000FE3;
    localparam logic [31:0] VADDVI = 32'h000FB057;
    localparam logic [31:0] SYS100 = 32'h0000C073;
    localparam logic [31:0] NOP    = 32'h00000013;

    exp_t sb_q[$];
    exp_t exp_b;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] kn_ins [4] = '{ADDI, SRAI, CSRRWI, LUI};
    logic [63:0] kn_imm [4] = '{64'hFFFFFFFFFFFFFFFF, 64'h3F, 64'h5, 64'hFFFFFFFF80000000};
    logic [2:0]  kn_fmt [4] = '{3'd1, 3'd6, 3'd7, 3'd4};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the drain and the accept that this edge will perform, then advance.
    task automatic cyc();
        exp_t e;
        if (!rstn_i || flush_i) begin
            sb_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output_valid", 64'(valid_o), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("lane_valid", 64'(lane_valid_o), 64'(e.lv));
                    for (int k = 0; k < 2; k++) begin
                        chk($sformatf("imm_l%0d", k), imm_o[64*k +: 64], e.imm[k]);
                        chk($sformatf("fmt_l%0d", k), 64'(imm_fmt_o[3*k +: 3]), 64'(e.fmt[k]));
                    end
                end
            end
            if (valid_i && ready_o) begin
                sb_q.push_back(exp_b);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [63:0] e0, input logic [2:0] f0,
                       input logic [63:0] e1, input logic [2:0] f1);
        valid_i      = 1'b1;
        lane_valid_i = lv;
        instr_i      = {i1, i0};
        exp_b.lv     = lv;
        exp_b.imm[0] = e0;
        exp_b.fmt[0] = f0;
        exp_b.imm[1] = e1;
        exp_b.fmt[1] = f1;
    endtask

    task automatic idle();
        valid_i      = 1'b0;
        lane_valid_i = 2'b00;
    endtask

    function automatic logic is_known(input logic [6:0] o);
        case (o)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0000111,
            7'b0100011, 7'b0100111, 7'b1100011, 7'b0010011, 7'b0011011, 7'b1110011,
            7'b1010111: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_unknown();
        logic [31:0] r;
        r = $urandom;
        while (is_known(r[6:0])) begin
            r[6:0] = 7'($urandom);
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0;
        logic [31:0] r1;
        int          pick;

        rstn_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        valid_i = 1'b0; lane_valid_i = 2'b00; instr_i = '0; exp_b = '0;
        flush32 = 1'b0; valid32 = 1'b0; lane_valid32 = 1'b0; instr32 = '0; ready32 = 1'b1;
        cyc();
        cyc();
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_lane_valid_o", 64'(lane_valid_o), 64'd0);
        chk("rst_imm_l0", imm_o[63:0], 64'd0);
        chk("rst_imm_l1", imm_o[127:64], 64'd0);
        chk("rst_fmt", 64'(imm_fmt_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
        rstn_i = 1'b1;
        cyc();
        chk("ready_after_reset", 64'(ready_o), 64'd1);

        // ADDI on lane 0 only, one-cycle latency.
        ready_i = 1'b1;
        put(2'b01, ADDI, NOP, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'd0, 3'd0);
        cyc();
        idle();
        chk("addi_valid_next_cycle", 64'(valid_o), 64'd1);
        cyc();
        chk("valid_after_drain", 64'(valid_o), 64'd0);

        // Two lanes: SW and JAL.
        put(2'b11, SW, JAL, 64'hFFFFFFFFFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFF8, 3'd5);
        cyc();
        idle();
        cyc();

        // Back-to-back single-lane decodes; the 32-bit instance runs alongside.
        valid32 = 1'b1; lane_valid32 = 1'b1; instr32 = LUI;
        put(2'b01, SRAI, NOP, 64'h3F, 3'd6, 64'd0, 3'd0);
        cyc();
        chk("x32_lui_valid", 64'(valid_o32), 64'd1);
        chk("x32_lui_imm", 64'(imm32), 64'h80000000);
        chk("x32_lui_fmt", 64'(fmt32), 64'd4);
        instr32 = SLLIW;
        put(2'b01, CSRRWI, NOP, 64'h5, 3'd7, 64'd0, 3'd0);
        cyc();
        chk("x32_slliw_imm", 64'(imm32), 64'd0);
        chk("x32_slliw_fmt", 64'(fmt32), 64'd0);
        instr32 = SRAI;
        put(2'b01, LUI, NOP, 64'hFFFFFFFF80000000, 3'd4, 64'd0, 3'd0);
        cyc();
        chk("x32_srai_imm", 64'(imm32), 64'h1F);
        chk("x32_srai_fmt", 64'(fmt32), 64'd6);
        valid32 = 1'b0;
        put(2'b11, SLLIW, BEQ, 64'h1F, 3'd6, 64'hFFFFFFFFFFFFFFFE, 3'd3);
        cyc();
        put(2'b11, VADDVI, SYS100, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'd0, 3'd0);
        cyc();
        put(2'b10, LUI, CSRRWI, 64'd0, 3'd0, 64'h5, 3'd7);
        cyc();
        idle();
        cyc();

        // Stall: A then B with the consumer blocked.
        ready_i = 1'b0;
        put(2'b01, ADDI, NOP, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'd0, 3'd0);
        cyc();
        chk("ready_in_one", 64'(ready_o), 64'd1);
        put(2'b11, LUI, JAL, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFFFFFFFFF8, 3'd5);
        cyc();
        idle();
        chk("ready_in_two", 64'(ready_o), 64'd0);
        chk("hold_imm_a", imm_o[63:0], 64'hFFFFFFFFFFFFFFFF);
        cyc();
        chk("hold_valid", 64'(valid_o), 64'd1);
        chk("hold_fmt_a", 64'(imm_fmt_o[2:0]), 64'd1);
        ready_i = 1'b1;
        cyc();
        chk("ready_after_a_drain", 64'(ready_o), 64'd1);
        chk("valid_b_after_a", 64'(valid_o), 64'd1);
        cyc();
        chk("empty_after_b", 64'(valid_o), 64'd0);

        // Flush in TWO with a bundle on the input.
        ready_i = 1'b0;
        put(2'b01, ADDI, NOP, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'd0, 3'd0);
        cyc();
        put(2'b01, LUI, NOP, 64'hFFFFFFFF80000000, 3'd4, 64'd0, 3'd0);
        cyc();
        put(2'b11, SRAI, SRAI, 64'h3F, 3'd6, 64'h3F, 3'd6);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        idle();
        chk("flush_two_valid", 64'(valid_o), 64'd0);
        chk("flush_two_ready", 64'(ready_o), 64'd1);
        chk("flush_two_imm", imm_o[63:0], 64'd0);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flush_two_no_output", 64'(valid_o), 64'd0);
        end

        // Flush in ONE while the input handshake would otherwise complete.
        ready_i = 1'b0;
        put(2'b01, CSRRWI, NOP, 64'h5, 3'd7, 64'd0, 3'd0);
        cyc();
        put(2'b01, SRAI, NOP, 64'h3F, 3'd6, 64'd0, 3'd0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        idle();
        chk("flush_one_valid", 64'(valid_o), 64'd0);
        ready_i = 1'b1;
        cyc();
        chk("flush_one_no_output", 64'(valid_o), 64'd0);

        // Reset while holding one bundle.
        ready_i = 1'b0;
        put(2'b11, LUI, SW, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFFFFFFFFFC, 3'd2);
        cyc();
        idle();
        chk("pre_reset_valid", 64'(valid_o), 64'd1);
        rstn_i = 1'b0;
        cyc();
        rstn_i = 1'b1;
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_imm_l0", imm_o[63:0], 64'd0);
        chk("midrst_imm_l1", imm_o[127:64], 64'd0);
        chk("midrst_fmt", 64'(imm_fmt_o), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd1);

        // Random sweep: unknown opcodes mixed with known ones, random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            ready_i = 1'($urandom_range(0, 1));
            r1 = rand_unknown();
            if ($urandom_range(0, 1) == 1) begin
                r0 = rand_unknown();
                put(2'b11, r0, r1, 64'd0, 3'd0, 64'd0, 3'd0);
            end else begin
                pick = $urandom_range(0, 3);
                put(2'b11, kn_ins[pick], r1, kn_imm[pick], kn_fmt[pick], 64'd0, 3'd0);
            end
            cyc();
        end
        idle();
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
        end
        chk("final_valid", 64'(valid_o), 64'd0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
